// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the burst master: transfer types, fixed control
// encodings and the master FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef logic [2:0] ahb_master_state_t;

  localparam ahb_master_state_t ST_IDLE     = 3'd0;
  localparam ahb_master_state_t ST_NONSEQ   = 3'd1;
  localparam ahb_master_state_t ST_SEQ      = 3'd2;
  localparam ahb_master_state_t ST_BUSY     = 3'd3;
  localparam ahb_master_state_t ST_RD_DRAIN = 3'd4;

  function automatic logic [7:0] burst_bytes(input int unsigned beats);
    return 8'(beats << 2);
  endfunction

endpackage

// File: rtl/ahb_burst_master.sv
// AHB burst master: turns a command/stream front end into NONSEQ/SEQ word
// transfers with BUSY insertion, 1 KB address wrap, read capture and abort.
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic                             cmd_write,
  input  logic [$clog2(MAX_BEATS+1)-1:0]   cmd_beats,
  input  logic                             wdata_valid,
  output logic                             wdata_ready,
  input  logic [31:0]                      wdata,
  output logic                             rdata_valid,
  output logic [31:0]                      rdata,
  output logic                             done,
  output logic                             err,
  output htrans_t                          HTRANS,
  output logic [ADDR_W-1:0]                HADDR,
  output logic                             HWRITE,
  output logic [2:0]                       HSIZE,
  output logic [2:0]                       HBURST,
  output logic [7:0]                       HLENGTH,
  output logic [31:0]                      HWDATA,
  input  logic                             HREADY,
  input  logic                             HRESP,
  input  logic [31:0]                      HRDATA
);

  localparam int unsigned BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BEATS);
  localparam logic [BW-1:0] ONE_B = BW'(1);

  ahb_master_state_t r_state;
  htrans_t           r_htrans;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  logic [2:0]        r_hburst;
  logic [7:0]        r_hlength;
  logic [31:0]       r_hwdata;
  logic [BW-1:0]     r_remaining;
  logic              r_first;
  logic              r_rd_pend;
  logic              r_done;
  logic              r_err;

  logic              w_issue;
  logic              w_abort;
  logic              w_beat_done;
  logic              w_last;
  logic              w_cmd_ok;
  logic [ADDR_W-1:0] w_next_addr;

  always_comb begin
    w_issue     = (r_state == ST_NONSEQ) || (r_state == ST_SEQ);
    w_abort     = HRESP && (w_issue || r_rd_pend);
    w_beat_done = w_issue && HREADY && !HRESP;
    w_last      = (r_remaining == ONE_B);
    w_cmd_ok    = (cmd_addr[1:0] == 2'b00) && (cmd_beats != '0) && (cmd_beats <= MAX_B);
    // The burst wraps inside its 1 KB page rather than crossing it.
    w_next_addr = {r_haddr[ADDR_W-1:10], r_haddr[9:0] + 10'd4};
  end

  // wdata_ready flags the cycle in which wdata is loaded into HWDATA for the
  // next beat to be issued, so a stalled beat never consumes an extra word.
  always_comb begin
    wdata_ready = 1'b0;
    case (r_state)
      ST_IDLE:           wdata_ready = cmd_valid && w_cmd_ok && cmd_write && wdata_valid;
      ST_NONSEQ, ST_SEQ: wdata_ready = r_hwrite && w_beat_done && !w_last && wdata_valid;
      ST_BUSY:           wdata_ready = wdata_valid;
      default:           wdata_ready = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_htrans    <= HTRANS_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hburst    <= HBURST_SINGLE;
      r_hlength   <= '0;
      r_hwdata    <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_pend <= 1'b0;
      if (w_abort) begin
        r_state  <= ST_IDLE;
        r_htrans <= HTRANS_IDLE;
        r_err    <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cmd_valid) begin
              if (!w_cmd_ok) begin
                r_err <= 1'b1;
              end else begin
                r_haddr     <= cmd_addr;
                r_hwrite    <= cmd_write;
                r_hburst    <= (cmd_beats == ONE_B) ? HBURST_SINGLE : HBURST_INCR;
                r_hlength   <= burst_bytes(32'(cmd_beats));
                r_remaining <= cmd_beats;
                r_first     <= 1'b1;
                if (cmd_write && !wdata_valid) begin
                  r_state  <= ST_BUSY;
                  r_htrans <= HTRANS_BUSY;
                end else begin
                  r_state  <= ST_NONSEQ;
                  r_htrans <= HTRANS_NONSEQ;
                  if (cmd_write) r_hwdata <= wdata;
                end
              end
            end
          end

          ST_NONSEQ, ST_SEQ: begin
            if (HREADY) begin
              r_first <= 1'b0;
              if (!r_hwrite) r_rd_pend <= 1'b1;
              if (w_last) begin
                r_htrans <= HTRANS_IDLE;
                if (r_hwrite) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ST_RD_DRAIN;
                end
              end else begin
                r_remaining <= r_remaining - ONE_B;
                r_haddr     <= w_next_addr;
                if (!r_hwrite || wdata_valid) begin
                  r_state  <= ST_SEQ;
                  r_htrans <= HTRANS_SEQ;
                  if (r_hwrite) r_hwdata <= wdata;
                end else begin
                  r_state  <= ST_BUSY;
                  r_htrans <= HTRANS_BUSY;
                end
              end
            end
          end

          ST_BUSY: begin
            if (wdata_valid) begin
              r_hwdata <= wdata;
              if (r_first) begin
                r_state  <= ST_NONSEQ;
                r_htrans <= HTRANS_NONSEQ;
              end else begin
                r_state  <= ST_SEQ;
                r_htrans <= HTRANS_SEQ;
              end
            end
          end

          ST_RD_DRAIN: begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end

          default: begin
            r_state  <= ST_IDLE;
            r_htrans <= HTRANS_IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign rdata_valid = r_rd_pend;
  assign rdata       = r_rd_pend ? HRDATA : '0;
  assign done        = r_done;
  assign err         = r_err;
  assign HTRANS      = r_htrans;
  assign HADDR       = r_haddr;
  assign HWRITE      = r_hwrite;
  assign HSIZE       = HSIZE_WORD;
  assign HBURST      = r_hburst;
  assign HLENGTH     = r_hlength;
  assign HWDATA      = r_hwdata;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Bench for ahb_burst_master: transaction-level model of the burst plus a
// slave memory, checked against the DUT every cycle under random stimulus.
module tb_ahb_burst_master;
  import ahb_pkg::*;

  localparam int MAXB = 16;
  localparam int LIM  = 600;
  localparam int PH_IDLE = 0, PH_BUS = 1, PH_DRAIN = 2;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [4:0]  cmd_beats = '0;
  logic        wdata_valid = 1'b0, wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid, done, err;
  logic [31:0] rdata;
  htrans_t     HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA = '0;
  logic        HWRITE, HREADY = 1'b1, HRESP = 1'b0;
  logic [2:0]  HSIZE, HBURST;
  logic [7:0]  HLENGTH;

  always #5 HCLK = ~HCLK;

  ahb_burst_master #(.MAX_BEATS(16), .ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_beats(cmd_beats),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HLENGTH(HLENGTH), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  int checks = 0, errors = 0;

  // Transaction-level model state (describes the current cycle).
  int          m_phase = PH_IDLE;
  bit          m_valid = 0, m_fresh = 1, m_write = 0;
  logic [31:0] m_addr0 = '0;
  int          m_beats = 0, m_beat = 0, m_loaded = 0;
  bit          m_rd_pend = 0, m_done_due = 0, m_err_due = 0;
  logic [31:0] m_rd_word = '0;
  logic [31:0] mem [1024];
  logic [31:0] wsrc [64];

  // Observations of the DUT, compared with literals by directed tests.
  logic [31:0] obs_addr [$];
  logic [31:0] obs_rd [$];
  int n_done = 0, n_err = 0, n_busy = 0, n_wrdy = 0;

  // Stimulus knobs.
  int hr_pct = 100, wv_pct = 100, err_pct = 0;
  int stall_beat = -1, stall_left = 0, gap_word = -1, gap_left = 0;
  int resp_beat = -1, rst_beat = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_addr(input int b);
    logic [31:0] off;
    off = (m_addr0 + 32'(4 * b)) & 32'h3FF;
    return (m_addr0 & ~32'h3FF) | off;
  endfunction

  function automatic bit m_issued();
    return (m_phase == PH_BUS) && (!m_write || m_loaded > m_beat);
  endfunction

  function automatic bit cmd_bad(input logic [31:0] a, input int n);
    return (a[1:0] != 2'b00) || (n == 0) || (n > MAXB);
  endfunction

  function automatic bit exp_wrdy();
    if (m_phase == PH_IDLE)
      return cmd_valid && !cmd_bad(cmd_addr, int'(cmd_beats)) && cmd_write && wdata_valid;
    if (m_phase == PH_BUS && m_write && wdata_valid)
      return m_issued() ? (HREADY && !HRESP && (m_beat + 1 < m_beats)) : 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic do_check();
    logic [1:0] eh;
    eh = 2'b00;
    if (m_phase == PH_BUS) eh = m_issued() ? ((m_beat == 0) ? 2'b10 : 2'b11) : 2'b01;
    chk("htrans", 32'(HTRANS), 32'(eh));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == PH_IDLE));
    chk("wdata_ready", 32'(wdata_ready), 32'(exp_wrdy()));
    chk("rdata_valid", 32'(rdata_valid), 32'(m_rd_pend));
    if (m_rd_pend) chk("rdata", rdata, m_rd_word);
    chk("done", 32'(done), 32'(m_done_due));
    chk("err", 32'(err), 32'(m_err_due));
    chk("hsize", 32'(HSIZE), 32'd2);
    if (m_phase != PH_IDLE) begin
      chk("hwrite", 32'(HWRITE), 32'(m_write));
      chk("hburst", 32'(HBURST), (m_beats == 1) ? 32'd0 : 32'd1);
      chk("hlength", 32'(HLENGTH), 32'(4 * m_beats));
    end
    if (m_phase == PH_BUS) chk("haddr", HADDR, beat_addr(m_beat));
    if (m_issued() && m_write) chk("hwdata", HWDATA, wsrc[m_beat]);
    if (m_phase == PH_IDLE && m_fresh) begin
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'h0);
      chk("rst_hburst", 32'(HBURST), 32'h0);
      chk("rst_hlength", 32'(HLENGTH), 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
    end
    if ((HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) && HREADY && !HRESP)
      obs_addr.push_back(HADDR);
    if (HTRANS == HTRANS_BUSY) n_busy++;
    if (wdata_ready) n_wrdy++;
    if (rdata_valid) obs_rd.push_back(rdata);
    if (done) n_done++;
    if (err) n_err++;
  endtask

  task automatic model_update();
    bit nrp, ndone, nerr, wr, iss;
    logic [31:0] a;
    if (!HRESETn) begin
      m_phase = PH_IDLE; m_rd_pend = 0; m_done_due = 0; m_err_due = 0;
      m_fresh = 1; m_valid = 1; m_loaded = 0; m_beat = 0;
      return;
    end
    nrp = 0; ndone = 0; nerr = 0;
    wr = exp_wrdy();
    iss = m_issued();
    case (m_phase)
      PH_IDLE: if (cmd_valid) begin
        if (cmd_bad(cmd_addr, int'(cmd_beats))) nerr = 1;
        else begin
          m_addr0 = cmd_addr; m_write = cmd_write; m_beats = int'(cmd_beats);
          m_beat = 0; m_loaded = wr ? 1 : 0; m_phase = PH_BUS; m_fresh = 0;
        end
      end
      PH_BUS: begin
        if (HRESP && (iss || m_rd_pend)) begin
          nerr = 1; m_phase = PH_IDLE;
        end else begin
          if (wr) m_loaded++;
          if (iss && HREADY) begin
            a = beat_addr(m_beat);
            if (m_write) mem[a[11:2]] = wsrc[m_beat];
            else begin nrp = 1; m_rd_word = mem[a[11:2]]; end
            m_beat++;
            if (m_beat == m_beats) begin
              if (m_write) begin ndone = 1; m_phase = PH_IDLE; end
              else m_phase = PH_DRAIN;
            end
          end
        end
      end
      default: begin
        if (m_rd_pend && HRESP) nerr = 1; else ndone = 1;
        m_phase = PH_IDLE;
      end
    endcase
    m_rd_pend = nrp; m_done_due = ndone; m_err_due = nerr;
  endtask

  initial begin
    forever begin
      @(negedge HCLK);
      if (m_valid) do_check();
      model_update();
    end
  end

  task automatic tick();
    int idx;
    @(posedge HCLK); #1;
    HREADY = ($urandom_range(99) < hr_pct);
    if (m_issued() && m_beat == stall_beat && stall_left > 0) begin HREADY = 0; stall_left--; end
    idx = (m_phase == PH_BUS && m_loaded < 64) ? m_loaded : 0;
    wdata_valid = ($urandom_range(99) < wv_pct);
    if (m_phase == PH_BUS && m_write && m_loaded == gap_word && gap_left > 0) begin
      wdata_valid = 0; gap_left--;
    end
    wdata = wdata_valid ? wsrc[idx] : $urandom;
    HRESP = ($urandom_range(99) < err_pct);
    if (m_issued() && m_beat == resp_beat) HRESP = 1;
    HRDATA = m_rd_pend ? m_rd_word : $urandom;
    HRESETn = 1;
    if (m_phase == PH_BUS && m_beat == rst_beat) begin HRESETn = 0; rst_beat = -1; end
  endtask

  task automatic send_cmd(input logic [31:0] a, input bit w, input int n);
    int g;
    g = 0;
    while (m_phase != PH_IDLE && g < LIM) begin tick(); g++; end
    tick();
    cmd_addr = a; cmd_write = w; cmd_beats = 5'(n); cmd_valid = 1;
    tick();
    cmd_valid = 0;
    while (m_phase != PH_IDLE && g < LIM) begin tick(); g++; end
    checks++;
    if (g >= LIM) begin
      errors++;
      $display("FAIL burst_timeout: got %0d cycles expected below %0d", g, LIM);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int d0, e0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(posedge HCLK);
    tick();
    chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("reset_htrans", 32'(HTRANS), 32'h0);
    chk("reset_done_err", 32'({done, err, rdata_valid, wdata_ready}), 32'h0);

    // 4-beat write at 0x40
    for (int i = 0; i < 4; i++) wsrc[i] = 32'h11 * (i + 1);
    obs_addr.delete(); d0 = n_done;
    send_cmd(32'h40, 1, 4); settle(2);
    chk("wr_addr0", qget(obs_addr, 0), 32'h40);
    chk("wr_addr1", qget(obs_addr, 1), 32'h44);
    chk("wr_addr3", qget(obs_addr, 3), 32'h4C);
    chk("mem16", mem[16], 32'h11);
    chk("mem19", mem[19], 32'h44);
    chk("wr_done_count", 32'(n_done - d0), 32'h1);

    // 4-beat read of the same words
    obs_rd.delete();
    send_cmd(32'h40, 0, 4); settle(2);
    chk("rd_count", 32'(obs_rd.size()), 32'h4);
    chk("rd_word0", qget(obs_rd, 0), 32'h11);
    chk("rd_word1", qget(obs_rd, 1), 32'h22);
    chk("rd_word3", qget(obs_rd, 3), 32'h44);

    // HREADY low for 3 cycles on beat 2
    for (int i = 0; i < 4; i++) wsrc[i] = 32'hA0 + 32'(i);
    stall_beat = 1; stall_left = 3; n_wrdy = 0;
    send_cmd(32'h80, 1, 4); settle(2);
    chk("stall_wrdy_count", 32'(n_wrdy), 32'h4);
    chk("stall_mem33", mem[33], 32'hA1);
    stall_beat = -1;

    // wdata_valid dropped for 2 cycles mid-burst
    for (int i = 0; i < 4; i++) wsrc[i] = 32'hB0 + 32'(i);
    gap_word = 2; gap_left = 2; n_busy = 0;
    send_cmd(32'h100, 1, 4); settle(2);
    chk("gap_busy_cycles", 32'(n_busy), 32'h2);
    chk("gap_mem66", mem[66], 32'hB2);
    gap_word = -1;

    // error response on beat 3 of 8
    for (int i = 0; i < 8; i++) wsrc[i] = $urandom;
    resp_beat = 2; d0 = n_done; e0 = n_err;
    send_cmd(32'h200, 1, 8); settle(2);
    chk("resp_err_count", 32'(n_err - e0), 32'h1);
    chk("resp_no_done", 32'(n_done - d0), 32'h0);
    chk("resp_cmd_ready", 32'(cmd_ready), 32'h1);
    resp_beat = -1;

    // misaligned command rejected
    e0 = n_err; obs_addr.delete();
    send_cmd(32'h41, 1, 2); settle(2);
    chk("reject_err_count", 32'(n_err - e0), 32'h1);
    chk("reject_no_beats", 32'(obs_addr.size()), 32'h0);

    // 1 KB wrap
    obs_addr.delete();
    send_cmd(32'h3F8, 1, 4); settle(2);
    chk("wrap_addr0", qget(obs_addr, 0), 32'h3F8);
    chk("wrap_addr1", qget(obs_addr, 1), 32'h3FC);
    chk("wrap_addr2", qget(obs_addr, 2), 32'h000);
    chk("wrap_addr3", qget(obs_addr, 3), 32'h004);

    // reset mid-burst
    rst_beat = 2; d0 = n_done; e0 = n_err;
    send_cmd(32'h300, 1, 8); settle(2);
    chk("rst_no_done_err", 32'((n_done - d0) + (n_err - e0)), 32'h0);
    chk("rst_idle_haddr", HADDR, 32'h0);
    rst_beat = -1;

    // randomized bursts
    hr_pct = 75; wv_pct = 75; err_pct = 3;
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(9) == 0) a = a | 32'h1;
      for (int i = 0; i < 64; i++) wsrc[i] = $urandom;
      send_cmd(a, 1'($urandom_range(1)), int'($urandom_range(0, 18)));
    end
    settle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
